// File: rtl/riscv_defines.sv
// Shared core definitions: load data types and
// write-back FSM encoding.
package riscv_defines;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  typedef enum logic {
    WB_IDLE       = 1'b0,
    WB_WAIT_RVALID = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_load_align.sv
// Load data alignment and sign/zero extension
// of a word-aligned LSU read.
module riscv_load_align
  import riscv_defines::*;
(
  input  logic [1:0]  i_type,
  input  logic        i_sign,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_offset[1] ? i_rdata[31:16]
                         : i_rdata[15:0];
    w_byte = i_rdata[7:0];
    unique case (i_offset)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_wdata = i_rdata;
    unique case (1'b1)
      (i_type == DT_WORD): o_wdata = i_rdata;
      (i_type == DT_HALF):
        o_wdata = {{16{i_sign & w_half[15]}},
                   w_half};
      default:
        o_wdata = {{24{i_sign & w_byte[7]}},
                   w_byte};
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// Write-back stage: single outstanding load,
// aligned register-file write with DIFT tag.
module riscv_wb_stage
  import riscv_defines::*;
#(
  parameter bit TAG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        regfile_we_i,
  input  logic [4:0]  regfile_waddr_i,
  input  logic [1:0]  data_type_i,
  input  logic        data_sign_ext_i,
  input  logic [1:0]  data_addr_offset_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rdata_tag_i,
  output logic        wb_ready_o,
  output logic        regfile_we_o,
  output logic [4:0]  regfile_waddr_o,
  output logic [31:0] regfile_wdata_o,
  output logic        regfile_wdata_tag_o,
  output logic        wb_busy_o,
  output logic [4:0]  wb_busy_waddr_o,
  output logic        err_o
);

  wb_state_e   r_state;
  wb_state_e   w_state_nxt;
  logic [4:0]  r_waddr;
  logic [1:0]  r_type;
  logic        r_sign;
  logic [1:0]  r_off;
  logic        r_we;
  logic [4:0]  r_waddr_o;
  logic [31:0] r_wdata;
  logic        r_tag;
  logic        r_err;
  logic        w_ready;
  logic        w_done;
  logic        w_cap;
  logic        w_spur;
  logic [31:0] w_aligned;

  riscv_load_align u_align (
    .i_type   (r_type),
    .i_sign   (r_sign),
    .i_offset (r_off),
    .i_rdata  (data_rdata_i),
    .o_wdata  (w_aligned)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_done      = 1'b0;
    w_spur      = 1'b0;
    unique case (r_state)
      WB_IDLE: begin
        w_spur = data_rvalid_i;
        if (ex_valid_i && regfile_we_i)
          w_state_nxt = WB_WAIT_RVALID;
      end
      WB_WAIT_RVALID: begin
        // Ready follows rvalid so a new load can
        // enter in the same cycle the old one retires.
        w_ready = data_rvalid_i;
        w_done  = data_rvalid_i;
        if (data_rvalid_i &&
            !(ex_valid_i && regfile_we_i))
          w_state_nxt = WB_IDLE;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
    w_cap = w_ready & ex_valid_i & regfile_we_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WB_IDLE;
      r_waddr <= '0;
      r_type  <= '0;
      r_sign  <= 1'b0;
      r_off   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_waddr <= regfile_waddr_i;
        r_type  <= data_type_i;
        r_sign  <= data_sign_ext_i;
        r_off   <= data_addr_offset_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_waddr_o <= '0;
      r_wdata   <= '0;
      r_tag     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we <= w_done & (r_waddr != 5'd0);
      if (w_done) begin
        r_waddr_o <= r_waddr;
        r_wdata   <= w_aligned;
        r_tag     <= TAG_EN & data_rdata_tag_i;
      end
      if (w_spur)
        r_err <= 1'b1;
    end
  end

  assign wb_ready_o          = w_ready;
  assign regfile_we_o        = r_we;
  assign regfile_waddr_o     = r_waddr_o;
  assign regfile_wdata_o     = r_wdata;
  assign regfile_wdata_tag_o = TAG_EN ? r_tag : 1'b0;
  assign wb_busy_o           = (r_state == WB_WAIT_RVALID);
  assign wb_busy_waddr_o     = r_waddr;
  assign err_o               = r_err;

endmodule

// File: doc/riscv_wb_stage.md
Name: riscv_wb_stage

Overview:
Write-back stage between the EX/WB pipeline register and the register-file write port B.
- Consumes the EX-side valid/ready handshake (ex_valid, wb_ready).
- Tracks a single outstanding load and aligns/extends the returning LSU data.
- Issues a registered register-file write that carries a DIFT tag bit.
- Exports scoreboard status so the ID stage can stall load-use hazards.

Parameters:
TAG_EN, 1, 1 = propagate data_rdata_tag_i to regfile_wdata_tag_o; 0 = tag output tied to 0

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
ex_valid_i  input  1  EX stage presents an instruction
regfile_we_i  input  1  instruction is a load needing write-back
regfile_waddr_i  input  5  load destination register
data_type_i  input  2  00 word, 01 half, 10 byte (11 treated as byte)
data_sign_ext_i  input  1  1 = sign-extend half/byte
data_addr_offset_i  input  2  byte offset of load address
data_rvalid_i  input  1  LSU read data valid
data_rdata_i  input  32  LSU read data, word-aligned
data_rdata_tag_i  input  1  DIFT tag of read data
wb_ready_o  output  1  WB can accept from EX
regfile_we_o  output  1  register-file write enable
regfile_waddr_o  output  5  write address
regfile_wdata_o  output  32  write data
regfile_wdata_tag_o  output  1  write data tag
wb_busy_o  output  1  load outstanding
wb_busy_waddr_o  output  5  destination of outstanding load
err_o  output  1  sticky: rvalid received while idle

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except wb_ready_o=1. Captured fields cleared. A pending load is dropped. A reset asserted mid-WAIT returns to IDLE and emits no write.
- FSM states: IDLE, WAIT_RVALID.
- IDLE:
  - wb_ready_o=1.
  - ex_valid_i & regfile_we_i → capture waddr, type, sign_ext, offset; go to WAIT_RVALID.
  - ex_valid_i & ~regfile_we_i → no state change.
- WAIT_RVALID:
  - wb_ready_o = data_rvalid_i (combinational), so the load-to-load back-to-back sequence has no bubble.
  - On data_rvalid_i:
    - Compute aligned data.
    - Register outputs: regfile_we_o=1 next cycle (1-cycle latency from rvalid), with waddr, wdata and tag.
    - If ex_valid_i & regfile_we_i in the same cycle → capture the new load and stay in WAIT_RVALID; otherwise → IDLE.
- regfile_we_o is a one-cycle pulse; it deasserts the following cycle unless another rvalid completes.
- Write to x0 (captured waddr==0): regfile_we_o stays 0; the FSM still completes.
- Alignment:
  - Word: data unchanged; offset ignored.
  - Half: select rdata[31:16] if offset[1], else rdata[15:0]; offset[0] ignored (misaligned accesses are split upstream).
  - Byte: select byte rdata[8*offset+7 : 8*offset].
  - Extension: zero- or sign-extend to 32 per data_sign_ext_i.
- Tag: regfile_wdata_tag_o = data_rdata_tag_i registered with the data when TAG_EN=1; constant 0 otherwise.
- Scoreboard:
  - wb_busy_o=1 iff state==WAIT_RVALID.
  - wb_busy_waddr_o = captured waddr; it holds its last value when not busy.
- err_o: set on data_rvalid_i in IDLE (the data is discarded, no write); cleared only by reset.
- No buffering beyond one outstanding load. EX must not present a second load unless wb_ready_o=1.

Decomposition:
- Shared package (riscv_defines) gets:
  - Data-type constants: DT_WORD=2'b00, DT_HALF=2'b01, DT_BYTE=2'b10.
  - WB FSM state enum.
- One sub-module, riscv_load_align: purely combinational alignment plus sign/zero extension (type, sign, offset, rdata → wdata). It is reused by verification as a reference model.
- The FSM, capture registers and output registers stay in the top module.

Test Plan:
- Byte signed load: waddr=5, type=10, sign=1, offset=2, rdata=0x0080_0000 two cycles later → one cycle after rvalid: we=1, waddr=5, wdata=0xFFFF_FF80; wb_busy_o high for exactly the wait cycles.
- Half unsigned with tag: offset=2, rdata=0xBEEF_1234, tag=1 → wdata=0x0000_BEEF, tag=1. Repeat with TAG_EN=0 → tag=0.
- Back-to-back loads: rvalid for load A (x3, rdata=0x11) coincides with ex_valid for load B (x4) → wb_ready_o=1 in that cycle; x3 is written next cycle; state stays WAIT; wb_busy_waddr_o=4; load B completes normally.
- x0 destination word load with rvalid → regfile_we_o never asserted; FSM returns to IDLE; wb_ready_o=1.
- Spurious rvalid in IDLE → no write; err_o=1 and it stays set until reset.
- Reset asserted during WAIT_RVALID, then rvalid → after release: IDLE, no write, err_o=1 (spurious rvalid); all outputs at reset values during reset.
